// File: rtl/slideshow_pkg.sv
// Shared types and helpers for the photo-frame slideshow scheduler.
// Index stepping wraps modulo the number of stored photos.
package slideshow_pkg;

    localparam int PHOTO_W = 3;
    localparam int SEC_W   = 4;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_ACK,
        S_LOAD,
        S_SHOW
    } state_e;

    typedef enum logic [1:0] {
        P_NONE,
        P_NEXT,
        P_PREV
    } pend_e;

    function automatic logic [PHOTO_W-1:0] stepIndex(
        input logic [PHOTO_W-1:0] idx,
        input pend_e              dir,
        input int                 num
    );
        logic [PHOTO_W-1:0] last;
        last = PHOTO_W'(num - 1);
        case (dir)
            P_NEXT:  stepIndex = (idx == last) ? '0 : idx + PHOTO_W'(1);
            P_PREV:  stepIndex = (idx == '0) ? last : idx - PHOTO_W'(1);
            default: stepIndex = idx;
        endcase
    endfunction

endpackage

// File: rtl/slideshow_sec_tick_gen.sv
// One-second tick generator for the auto-advance dwell timer.
// Counts enabled cycles; iCLR restarts the second from zero.
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic iCLR,
    input  logic iEN,
    output logic oTICK
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign oTICK  = iEN && !iCLR && w_wrap;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_cnt <= '0;
        end else if (iCLR) begin
            r_cnt <= '0;
        end else if (iEN) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/slideshow_scheduler.sv
// Decides which photo the flash-to-SDRAM copier loads next and when,
// from next/prev pulses or the auto dwell timer, with a one-deep request queue.
module slideshow_scheduler
    import slideshow_pkg::*;
#(
    parameter int PHOTO_NUM   = 6,
    parameter int TICK_DIV    = 50_000_000,
    parameter int DWELL_SEC   = 5,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iNEXT,
    input  logic               iPREV,
    input  logic               iAUTO,
    input  logic               iLOAD_BUSY,
    output logic               oLOAD_REQ,
    output logic [PHOTO_W-1:0] oPHOTO_CNT,
    output logic [SEC_W-1:0]   oSEC_LEFT,
    output logic               oERR,
    output logic [2:0]         oSTATE
);

    localparam int               AW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0]    ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [SEC_W-1:0] DWELL    = SEC_W'(DWELL_SEC);

    state_e             r_state, w_stateNext;
    pend_e              r_pend, w_pendNext, w_req, w_pendEff;
    logic [PHOTO_W-1:0] r_photo, w_photoNext;
    logic [SEC_W-1:0]   r_sec;
    logic [AW-1:0]      r_ackCnt;
    logic               r_err, r_loadReq;
    logic               w_errSet, w_tick, w_tickClr, w_tickEn, w_showEntry;

    assign oLOAD_REQ  = r_loadReq;
    assign oPHOTO_CNT = r_photo;
    assign oSEC_LEFT  = r_sec;
    assign oERR       = r_err;
    assign oSTATE     = r_state;

    assign w_tickClr   = (r_state != S_SHOW);
    assign w_tickEn    = iAUTO && (r_state == S_SHOW);
    assign w_showEntry = (w_stateNext == S_SHOW) && (r_state != S_SHOW);

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .iCLR  (w_tickClr),
        .iEN   (w_tickEn),
        .oTICK (w_tick)
    );

    // Conflicting next+prev in one cycle cancel out; a lone request overrides any queued one.
    always_comb begin
        w_req = P_NONE;
        if (iNEXT && !iPREV) begin
            w_req = P_NEXT;
        end else if (iPREV && !iNEXT) begin
            w_req = P_PREV;
        end
    end

    assign w_pendEff = (w_req != P_NONE) ? w_req : r_pend;

    always_comb begin
        w_stateNext = r_state;
        w_pendNext  = r_pend;
        w_photoNext = r_photo;
        w_errSet    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_stateNext = S_REQ;
                w_pendNext  = P_NONE;
            end
            S_REQ: begin
                w_stateNext = S_ACK;
                w_pendNext  = w_pendEff;
            end
            S_ACK: begin
                w_pendNext = w_pendEff;
                if (iLOAD_BUSY) begin
                    w_stateNext = S_LOAD;
                end else if (r_ackCnt == ACK_LAST) begin
                    w_errSet    = 1'b1;
                    w_stateNext = S_SHOW;
                    w_pendNext  = P_NONE;
                end
            end
            S_LOAD: begin
                w_pendNext = w_pendEff;
                if (!iLOAD_BUSY) begin
                    w_pendNext = P_NONE;
                    if (w_pendEff != P_NONE) begin
                        w_photoNext = stepIndex(r_photo, w_pendEff, PHOTO_NUM);
                        w_stateNext = S_REQ;
                    end else begin
                        w_stateNext = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                w_pendNext = P_NONE;
                if (w_req != P_NONE) begin
                    w_photoNext = stepIndex(r_photo, w_req, PHOTO_NUM);
                    w_stateNext = S_REQ;
                end else if (iAUTO && (r_sec == '0)) begin
                    w_photoNext = stepIndex(r_photo, P_NEXT, PHOTO_NUM);
                    w_stateNext = S_REQ;
                end
            end
            default: begin
                w_stateNext = S_BOOT;
                w_pendNext  = P_NONE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state   <= S_BOOT;
            r_pend    <= P_NONE;
            r_photo   <= '0;
            r_loadReq <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pend    <= w_pendNext;
            r_photo   <= w_photoNext;
            r_loadReq <= (w_stateNext == S_REQ);
        end
    end

    // Counts cycles spent waiting for the copier to raise busy.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_ackCnt <= '0;
        end else if (r_state == S_ACK) begin
            r_ackCnt <= r_ackCnt + AW'(1);
        end else begin
            r_ackCnt <= '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_err <= 1'b0;
        end else if (w_errSet) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sec <= DWELL;
        end else if (w_showEntry) begin
            r_sec <= DWELL;
        end else if ((r_state == S_SHOW) && w_tick && (r_sec != '0)) begin
            r_sec <= r_sec - SEC_W'(1);
        end
    end

endmodule
